// File: rtl/fixed_truncate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fixed_truncate_pipe
// Purpose  : Two-stage valid/ready requantiser. It scales a two's-complement
//            IN_W-bit sample by 2^-SHIFT, optionally rounds half away from
//            zero, then saturates or wraps into OUT_W bits. It also counts
//            the out-of-range samples that are delivered downstream.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_truncate_pipe #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_round,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_clr
);

    // Quotient width: one bit wider than IN_W-SHIFT so the rounding carry
    // out of the most negative input magnitude is preserved.
    localparam int c_q_w = IN_W - SHIFT + 1;

    // Largest positive magnitude, 2^(OUT_W-1)-1, and largest negative
    // magnitude, 2^(OUT_W-1), expressed at quotient width.
    localparam logic [c_q_w-1:0] c_pos_lim = {{(c_q_w-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [c_q_w-1:0] c_q_one   = {{(c_q_w-1){1'b0}}, 1'b1};
    localparam logic [c_q_w-1:0] c_neg_lim = c_pos_lim + c_q_one;

    localparam logic [OUT_W-1:0] c_sat_pos = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] c_sat_neg = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic w_s2_load;
    logic w_s1_load;

    assign w_s2_load = !out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // ------------------------------------------------------------------
    // Stage 0 (combinational): sign/magnitude split and rounded quotient
    // ------------------------------------------------------------------
    logic              w_sign;
    logic [IN_W:0]     w_ext;
    logic [IN_W:0]     w_mag;
    logic              w_round_up;
    logic [c_q_w-1:0]  w_q;

    assign w_sign     = in_data[IN_W-1];
    assign w_ext      = {in_data[IN_W-1], in_data};
    assign w_mag      = w_sign ? -w_ext : w_ext;
    assign w_round_up = in_round & w_mag[SHIFT-1];
    assign w_q        = w_mag[IN_W:SHIFT] + {{(c_q_w-1){1'b0}}, w_round_up};

    logic             r_s1_sign;
    logic [c_q_w-1:0] r_s1_q;
    logic             r_s1_sat_en;

    // Stage 1 register: capture sign, quotient and per-sample sat mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_q      <= '0;
            r_s1_sat_en <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign   <= w_sign;
                r_s1_q      <= w_q;
                r_s1_sat_en <= sat_en;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 -> 2 (combinational): range check and result selection
    // ------------------------------------------------------------------
    logic             w_oor;
    logic [c_q_w-1:0] w_signed;
    logic [OUT_W-1:0] w_result;

    // Negative side admits one extra magnitude step (-2^(OUT_W-1)).
    assign w_oor    = r_s1_sign ? (r_s1_q > c_neg_lim) : (r_s1_q > c_pos_lim);
    // A zero quotient negates to zero, so negative zero cannot appear.
    assign w_signed = r_s1_sign ? -r_s1_q : r_s1_q;
    // In range and wrap both take the low OUT_W bits of the signed result.
    assign w_result = (w_oor && r_s1_sat_en) ? (r_s1_sign ? c_sat_neg : c_sat_pos)
                                             : w_signed[OUT_W-1:0];

    // Fractional bits and high signed bits are discarded by design.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_mag[SHIFT-1:0], w_signed[c_q_w-1:OUT_W]};

    // Stage 2 register: output sample, holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (w_s2_load) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data <= w_result;
                out_sat  <= w_oor;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturation statistics
    // ------------------------------------------------------------------
    logic w_sat_pop;
    assign w_sat_pop = out_valid & out_ready & out_sat;

    // Count delivered out-of-range samples; clear has priority, sticks at max
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (w_sat_pop && (sat_cnt != {CNT_W{1'b1}})) begin
            sat_cnt <= sat_cnt + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_truncate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_truncate_pipe
// Purpose  : Directed and randomized bench for fixed_truncate_pipe with an
//            arithmetic reference model and an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_truncate_pipe;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 9;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_round = 1'b0;
    logic             sat_en = 1'b1;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic [CNT_W-1:0] sat_cnt;
    logic             sat_clr = 1'b0;

    logic             in_ready2;
    logic             out_valid2;
    logic [OUT_W-1:0] out_data2;
    logic             out_sat2;
    logic [1:0]       sat_cnt2;

    fixed_truncate_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_round(in_round), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    // Narrow-counter instance sharing the same stimulus
    fixed_truncate_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_round(in_round), .sat_en(sat_en),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_sat(out_sat2), .sat_cnt(sat_cnt2), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sat;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic             last_acc = 1'b0;
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;
    logic             prev_sat = 1'b0;
    logic             chk_lat = 1'b0;
    logic             rnd_ready = 1'b0;
    logic             use_exp = 1'b0;
    logic [OUT_W-1:0] cur_d = '0;
    logic             cur_s = 1'b0;

    // Reference: plain integer arithmetic on the sample value
    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d, input logic rnd, input logic sat);
        longint v, mag, q, lim, half, r;
        logic   oor;
        v    = longint'($signed(d));
        mag  = (v < 0) ? -v : v;
        half = longint'(1) << (SHIFT - 1);
        q    = (mag + (rnd ? half : 64'sd0)) / (2 * half);
        lim  = longint'(1) << (OUT_W - 1);
        oor  = (v < 0) ? (q > lim) : (q > lim - 1);
        r    = (v < 0) ? -q : q;
        if (oor && sat) r = (v < 0) ? -lim : lim - 1;
        return {oor, r[OUT_W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the DUT at the falling edge: flow control, stability, scoreboard
    task automatic mon();
        exp_t  e;
        logic [OUT_W:0] m;
        if (!rst_n) begin
            sb.delete();
            prev_stall = 1'b0;
            last_acc   = 1'b0;
            return;
        end
        chk("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_sat", out_sat, prev_sat);
        end
        if (sb.size() == 0) begin
            chk("idle_out_valid", out_valid, 0);
        end else if (out_valid && out_ready) begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_sat", out_sat, e.sat);
            if (chk_lat) chk("latency", cyc - e.cyc, 2);
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            m = model(in_data, in_round, sat_en);
            e.data = use_exp ? cur_d : m[OUT_W-1:0];
            e.sat  = use_exp ? cur_s : m[OUT_W];
            e.cyc  = cyc;
            sb.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_sat   = out_sat;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic rnd, input logic sat,
                        input logic ue, input logic [OUT_W-1:0] ed, input logic es);
        int n;
        in_data  = d;
        in_round = rnd;
        sat_en   = sat;
        in_valid = 1'b1;
        use_exp  = ue;
        cur_d    = ed;
        cur_s    = es;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        chk("accept_timeout", last_acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        tick();
    endtask

    logic [IN_W-1:0]  dir_d  [15] = '{32'h00001200, 32'hFFFFEE00, 32'h00000000, 32'h00001300,
                                      32'h00001300, 32'hFFFFED00, 32'hFFFFED00, 32'h000013FF,
                                      32'h01000000, 32'h01000000, 32'hFF000000, 32'hFEFFFE00,
                                      32'h00FFFF00, 32'h00FFFF00, 32'h00000200};
    logic             dir_r  [15] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    logic             dir_s  [15] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    logic [OUT_W-1:0] dir_e  [15] = '{16'h0009, 16'hFFF7, 16'h0000, 16'h0009, 16'h000A,
                                      16'hFFF7, 16'hFFF6, 16'h000A, 16'h7FFF, 16'h8000,
                                      16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0001};
    logic             dir_es [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0};

    initial begin
        logic [IN_W-1:0]        base;
        logic signed [IN_W-1:0] tmp;
        int                     n;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_after_reset", in_ready, 1);

        // Directed exact, sign, tie and range cases with latency tracking
        chk_lat = 1'b1;
        for (int i = 0; i < 14; i++)
            send(dir_d[i], dir_r[i], dir_s[i], 1'b1, dir_e[i], dir_es[i]);
        drain();
        chk_lat = 1'b0;

        // Eight incrementing samples under random backpressure
        base = $urandom;
        rnd_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            send(base + IN_W'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        drain();

        // Mixed-magnitude random samples under random backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tmp = $signed($urandom);
            tmp = tmp >>> $urandom_range(0, 20);
            send(tmp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        end
        drain();

        // Counter: three saturating deliveries
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("cnt_cleared", sat_cnt, 0);
        for (int i = 0; i < 3; i++) send(32'h01000000, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        drain();
        chk("cnt_three", sat_cnt, 3);

        // Clear coincident with a saturating pop wins
        out_ready = 1'b0;
        send(32'h01000000, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("held_valid", out_valid, 1);
        out_ready = 1'b1;
        sat_clr   = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_wins", sat_cnt, 0);
        chk("clr_wins_popped", out_valid, 0);
        chk("clr_wins_narrow", sat_cnt2, 0);

        // Five saturating deliveries: wide counter 5, 2-bit counter sticks at 3
        for (int i = 0; i < 5; i++) send(32'hFEFFFE00, 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        drain();
        chk("cnt_five", sat_cnt, 5);
        chk("cnt_stick", sat_cnt2, 3);

        // Reset with both stages full
        out_ready = 1'b0;
        send(32'h01000000, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        send(32'h01000000, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_sat_cnt", sat_cnt, 0);
        chk("async_sat_cnt_narrow", sat_cnt2, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("ready_after_midreset", in_ready, 1);
        chk_lat = 1'b1;
        send(dir_d[14], dir_r[14], dir_s[14], 1'b1, dir_e[14], dir_es[14]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
